// File: rtl/rdata_demux.sv
// AXI read-data demultiplexer: a fixed number of header beats per frame is
// captured into hdr_data, then payload beats are striped round-robin across NUM_CH FIFOs.
module rdata_demux #(
  parameter int unsigned DATA_W    = 1024,
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned HDR_BEATS = 6,
  parameter int unsigned NUM_CH    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             m_axi_rdata,
  input  logic [ID_WIDTH-1:0]           m_axi_rid,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  input  logic [1:0]                    m_axi_rresp,
  output logic                          m_axi_rready,
  input  logic                          start_pulse,
  input  logic [15:0]                   frame_groups,
  output logic [HDR_BEATS*DATA_W-1:0]   hdr_data,
  output logic                          hdr_valid,
  output logic [NUM_CH*DATA_W-1:0]      ch_din,
  output logic [NUM_CH-1:0]             ch_wr,
  input  logic [NUM_CH-1:0]             ch_full,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_error
);

  localparam int unsigned HCNT_W = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int unsigned CCNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned GCNT_W = $clog2(65536);
  localparam int unsigned STG_N  = (NUM_CH > 1) ? NUM_CH - 1 : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_e;

  state_e                     state_q;
  logic [HCNT_W-1:0]          hdr_cnt_q;
  logic [CCNT_W-1:0]          ch_idx_q;
  logic [GCNT_W-1:0]          grp_cnt_q;
  logic [GCNT_W-1:0]          groups_q;
  logic [DATA_W-1:0]          hdr_q   [HDR_BEATS];
  logic [DATA_W-1:0]          stage_q [STG_N];
  logic [NUM_CH*DATA_W-1:0]   ch_din_q;
  logic [NUM_CH-1:0]          ch_wr_q;
  logic                       hdr_valid_q;
  logic                       done_q;
  logic                       rd_error_q;

  logic                       accept;
  logic                       hdr_acc;
  logic                       pay_acc;
  logic                       hdr_last;
  logic                       grp_last;
  logic [GCNT_W:0]            grp_cnt_d;
  logic [NUM_CH*DATA_W-1:0]   grp_word_d;
  logic                       unused_sigs;

  assign unused_sigs = ^{m_axi_rid, m_axi_rlast};

  // Holding rready low during start_pulse keeps a beat from being consumed
  // by the frame that is being abandoned.
  always_comb begin
    m_axi_rready = 1'b0;
    if (!start_pulse) begin
      unique case (state_q)
        HDR:     m_axi_rready = 1'b1;
        PAY:     m_axi_rready = ~|ch_full;
        default: m_axi_rready = 1'b0;
      endcase
    end
  end

  assign accept    = m_axi_rvalid && m_axi_rready;
  assign hdr_acc   = accept && (state_q == HDR);
  assign pay_acc   = accept && (state_q == PAY);
  assign hdr_last  = (hdr_cnt_q == HCNT_W'(HDR_BEATS - 1));
  assign grp_last  = (NUM_CH == 1) || (ch_idx_q == CCNT_W'(NUM_CH - 1));
  assign grp_cnt_d = {1'b0, grp_cnt_q} + 1'b1;

  for (genvar c = 0; c < NUM_CH - 1; c++) begin : g_word
    assign grp_word_d[c*DATA_W +: DATA_W] = stage_q[c];
  end
  assign grp_word_d[(NUM_CH-1)*DATA_W +: DATA_W] = m_axi_rdata;

  for (genvar i = 0; i < HDR_BEATS; i++) begin : g_hdr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hdr_q[i] <= '0;
      end else if (hdr_acc && (hdr_cnt_q == HCNT_W'(i))) begin
        hdr_q[i] <= m_axi_rdata;
      end
    end
    assign hdr_data[i*DATA_W +: DATA_W] = hdr_q[i];
  end

  for (genvar c = 0; c < STG_N; c++) begin : g_stg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[c] <= '0;
      end else if (pay_acc && (NUM_CH > 1) && (ch_idx_q == CCNT_W'(c))) begin
        stage_q[c] <= m_axi_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= '0;
      ch_idx_q    <= '0;
      grp_cnt_q   <= '0;
      groups_q    <= '0;
      ch_din_q    <= '0;
      ch_wr_q     <= '0;
      hdr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rd_error_q  <= 1'b0;
    end else begin
      hdr_valid_q <= 1'b0;
      ch_wr_q     <= '0;
      done_q      <= 1'b0;
      if (start_pulse) begin
        state_q    <= HDR;
        hdr_cnt_q  <= '0;
        ch_idx_q   <= '0;
        grp_cnt_q  <= '0;
        groups_q   <= frame_groups;
        rd_error_q <= 1'b0;
      end else begin
        if (accept && (m_axi_rresp != 2'b00)) begin
          rd_error_q <= 1'b1;
        end
        unique case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          HDR: begin
            if (accept) begin
              if (hdr_last) begin
                hdr_valid_q <= 1'b1;
                hdr_cnt_q   <= '0;
                state_q     <= (groups_q == '0) ? DONE : PAY;
              end else begin
                hdr_cnt_q <= hdr_cnt_q + 1'b1;
              end
            end
          end
          PAY: begin
            if (accept) begin
              if (grp_last) begin
                ch_din_q  <= grp_word_d;
                ch_wr_q   <= '1;
                ch_idx_q  <= '0;
                grp_cnt_q <= grp_cnt_d[GCNT_W-1:0];
                if (grp_cnt_d == {1'b0, groups_q}) begin
                  state_q <= DONE;
                end
              end else begin
                ch_idx_q <= ch_idx_q + 1'b1;
              end
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign ch_din    = ch_din_q;
  assign ch_wr     = ch_wr_q;
  assign hdr_valid = hdr_valid_q;
  assign done      = done_q;
  assign rd_error  = rd_error_q;
  assign busy      = (state_q == HDR) || (state_q == PAY);

endmodule
